// File: rtl/inst_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_buffer_pkg
// Brief    : Shared types and constants for the dual-issue instruction buffer.
// Revision : 1.0 - initial release
// ============================================================================
package inst_buffer_pkg;

    localparam int c_ib_depth = 8;
    localparam int c_pc_w     = 32;
    localparam int c_inst_w   = 32;
    localparam int c_cause_w  = 7;

    // Exception codes carried alongside fetched instructions
    localparam logic [c_cause_w-1:0] c_exception_int  = 7'h00;
    localparam logic [c_cause_w-1:0] c_exception_pif  = 7'h03;
    localparam logic [c_cause_w-1:0] c_exception_ppi  = 7'h07;
    localparam logic [c_cause_w-1:0] c_exception_adef = 7'h08;
    localparam logic [c_cause_w-1:0] c_exception_ale  = 7'h09;
    localparam logic [c_cause_w-1:0] c_exception_sys  = 7'h0b;
    localparam logic [c_cause_w-1:0] c_exception_brk  = 7'h0c;
    localparam logic [c_cause_w-1:0] c_exception_ine  = 7'h0d;

    typedef struct packed {
        logic [c_pc_w-1:0]    pc;
        logic [c_inst_w-1:0]  inst;
        logic                 pred_taken;
        logic                 excp;
        logic [c_cause_w-1:0] cause;
    } ib_entry_t;

    localparam int c_entry_w = $bits(ib_entry_t);

    // Zero an entry whose slot is not valid so decode never sees stale data
    function automatic ib_entry_t ib_gate(input ib_entry_t e, input logic valid);
        return valid ? e : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_buffer_if
// Brief    : Fetch-side write, decode-side read and pc-stall signals of the buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_buffer_if;
    import inst_buffer_pkg::*;

    logic                 flush;

    logic                 in_valid1;
    logic                 in_valid2;
    logic [c_pc_w-1:0]    in_pc1;
    logic [c_pc_w-1:0]    in_pc2;
    logic [c_inst_w-1:0]  in_inst1;
    logic [c_inst_w-1:0]  in_inst2;
    logic                 in_pred_taken1;
    logic                 in_pred_taken2;
    logic                 in_excp1;
    logic                 in_excp2;
    logic [c_cause_w-1:0] in_excp_cause1;
    logic [c_cause_w-1:0] in_excp_cause2;

    logic                 out_ready1;
    logic                 out_ready2;
    logic                 out_valid1;
    logic                 out_valid2;
    logic [c_pc_w-1:0]    out_pc1;
    logic [c_pc_w-1:0]    out_pc2;
    logic [c_inst_w-1:0]  out_inst1;
    logic [c_inst_w-1:0]  out_inst2;
    logic                 out_pred_taken1;
    logic                 out_pred_taken2;
    logic                 out_excp1;
    logic                 out_excp2;
    logic [c_cause_w-1:0] out_excp_cause1;
    logic [c_cause_w-1:0] out_excp_cause2;

    logic                 stall_to_pc;

    modport master (
        output flush,
        output in_valid1, in_valid2, in_pc1, in_pc2, in_inst1, in_inst2,
        output in_pred_taken1, in_pred_taken2, in_excp1, in_excp2,
        output in_excp_cause1, in_excp_cause2,
        output out_ready1, out_ready2,
        input  out_valid1, out_valid2, out_pc1, out_pc2, out_inst1, out_inst2,
        input  out_pred_taken1, out_pred_taken2, out_excp1, out_excp2,
        input  out_excp_cause1, out_excp_cause2,
        input  stall_to_pc
    );

    modport slave (
        input  flush,
        input  in_valid1, in_valid2, in_pc1, in_pc2, in_inst1, in_inst2,
        input  in_pred_taken1, in_pred_taken2, in_excp1, in_excp2,
        input  in_excp_cause1, in_excp_cause2,
        input  out_ready1, out_ready2,
        output out_valid1, out_valid2, out_pc1, out_pc2, out_inst1, out_inst2,
        output out_pred_taken1, out_pred_taken2, out_excp1, out_excp2,
        output out_excp_cause1, out_excp_cause2,
        output stall_to_pc
    );

endinterface
`default_nettype wire

// File: rtl/inst_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module   : inst_buffer_ram
// Brief    : 2-write / 2-read register array holding buffer entries; data not reset.
// Revision : 1.0 - initial release
// ============================================================================
module inst_buffer_ram
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = c_ib_depth,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             i_we0,
    input  wire logic [PTR_W-1:0] i_waddr0,
    input  wire ib_entry_t        i_wdata0,
    input  wire logic             i_we1,
    input  wire logic [PTR_W-1:0] i_waddr1,
    input  wire ib_entry_t        i_wdata1,
    input  wire logic [PTR_W-1:0] i_raddr0,
    input  wire logic [PTR_W-1:0] i_raddr1,
    output ib_entry_t             o_rdata0,
    output ib_entry_t             o_rdata1
);

    ib_entry_t r_mem [DEPTH];

    // The two write addresses are always consecutive, so they never collide
    always_ff @(posedge clk) begin
        if (i_we0) begin
            r_mem[i_waddr0] <= i_wdata0;
        end
        if (i_we1) begin
            r_mem[i_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule
`default_nettype wire

// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
// Module   : inst_buffer
// Brief    : Dual-issue in-order instruction queue between fetch and decode.
// Revision : 1.0 - initial release
// ============================================================================
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = c_ib_depth,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic   clk,
    input  wire logic   rst,
    inst_buffer_if.slave bus
);

    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] c_two   = (PTR_W+1)'(2);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic [PTR_W:0]   w_free;
    logic [1:0]       w_n_req;
    logic [1:0]       w_n_acc;
    logic [1:0]       w_n_rd;
    logic             w_valid1;
    logic             w_valid2;
    logic             w_pop1;
    logic             w_pop2;

    ib_entry_t        w_slot1;
    ib_entry_t        w_slot2;
    logic             w_we0;
    logic             w_we1;
    ib_entry_t        w_wdata0;
    logic [PTR_W-1:0] w_waddr1;
    logic [PTR_W-1:0] w_raddr1;
    ib_entry_t        w_head0;
    ib_entry_t        w_head1;
    ib_entry_t        w_out1;
    ib_entry_t        w_out2;

    // ------------------------------------------------------------------
    // Capacity and acceptance: only the registered count is trusted, a
    // same-cycle pop does not make room for a same-cycle write.
    // ------------------------------------------------------------------
    assign w_free  = c_depth - r_count;
    assign w_n_req = {1'b0, bus.in_valid1} + {1'b0, bus.in_valid2};

    always_comb begin
        w_n_acc = 2'd0;
        if (!bus.flush) begin
            if ((PTR_W+1)'(w_n_req) <= w_free) begin
                w_n_acc = w_n_req;
            end else begin
                w_n_acc = w_free[1:0];
            end
        end
    end

    // Compaction: the first valid slot always lands at wr_ptr
    assign w_slot1  = '{pc: bus.in_pc1, inst: bus.in_inst1, pred_taken: bus.in_pred_taken1,
                        excp: bus.in_excp1, cause: bus.in_excp_cause1};
    assign w_slot2  = '{pc: bus.in_pc2, inst: bus.in_inst2, pred_taken: bus.in_pred_taken2,
                        excp: bus.in_excp2, cause: bus.in_excp_cause2};
    assign w_we0    = (w_n_acc != 2'd0);
    assign w_we1    = (w_n_acc == 2'd2);
    assign w_wdata0 = bus.in_valid1 ? w_slot1 : w_slot2;
    assign w_waddr1 = r_wr_ptr + PTR_W'(1);

    // ------------------------------------------------------------------
    // Read side: show-ahead from the two head entries, strictly in order
    // ------------------------------------------------------------------
    assign w_valid1 = (r_count != '0);
    assign w_valid2 = (r_count >= c_two);
    assign w_pop1   = bus.out_ready1 & w_valid1;
    assign w_pop2   = w_pop1 & bus.out_ready2 & w_valid2;
    assign w_n_rd   = {1'b0, w_pop1} + {1'b0, w_pop2};
    assign w_raddr1 = r_rd_ptr + PTR_W'(1);

    inst_buffer_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk      (clk),
        .i_we0    (w_we0),
        .i_waddr0 (r_wr_ptr),
        .i_wdata0 (w_wdata0),
        .i_we1    (w_we1),
        .i_waddr1 (w_waddr1),
        .i_wdata1 (w_slot2),
        .i_raddr0 (r_rd_ptr),
        .i_raddr1 (w_raddr1),
        .o_rdata0 (w_head0),
        .o_rdata1 (w_head1)
    );

    // ------------------------------------------------------------------
    // Control state; flush outranks every other event
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_rd);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_acc);
            r_count  <= r_count + (PTR_W+1)'(w_n_acc) - (PTR_W+1)'(w_n_rd);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_out1 = ib_gate(w_head0, w_valid1);
    assign w_out2 = ib_gate(w_head1, w_valid2);

    assign bus.out_valid1      = w_valid1;
    assign bus.out_pc1         = w_out1.pc;
    assign bus.out_inst1       = w_out1.inst;
    assign bus.out_pred_taken1 = w_out1.pred_taken;
    assign bus.out_excp1       = w_out1.excp;
    assign bus.out_excp_cause1 = w_out1.cause;

    assign bus.out_valid2      = w_valid2;
    assign bus.out_pc2         = w_out2.pc;
    assign bus.out_inst2       = w_out2.inst;
    assign bus.out_pred_taken2 = w_out2.pred_taken;
    assign bus.out_excp2       = w_out2.excp;
    assign bus.out_excp_cause2 = w_out2.cause;

    assign bus.stall_to_pc     = (w_free < c_two);

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_buffer
// Brief    : Self-checking bench for inst_buffer against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ib_entry_t model_q[$];

    inst_buffer_if bus ();

    inst_buffer #(
        .DEPTH (DEPTH),
        .PTR_W (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic ib_entry_t mk(input logic [31:0] pc, input logic [31:0] inst);
        ib_entry_t e;
        e      = '0;
        e.pc   = pc;
        e.inst = inst;
        return e;
    endfunction

    function automatic ib_entry_t rand_entry();
        ib_entry_t e;
        e.pc         = $urandom();
        e.inst       = $urandom();
        e.pred_taken = 1'($urandom_range(0, 1));
        e.excp       = 1'($urandom_range(0, 1));
        e.cause      = 7'($urandom_range(0, 127));
        return e;
    endfunction

    function automatic logic [148:0] obs_vec();
        return {bus.out_valid1, bus.out_valid2, bus.stall_to_pc,
                bus.out_pc1, bus.out_inst1, bus.out_pred_taken1, bus.out_excp1, bus.out_excp_cause1,
                bus.out_pc2, bus.out_inst2, bus.out_pred_taken2, bus.out_excp2, bus.out_excp_cause2};
    endfunction

    // Expected view: first two queued instructions, zero where absent
    function automatic logic [148:0] exp_vec();
        ib_entry_t e1 = '0;
        ib_entry_t e2 = '0;
        logic v1, v2, st;
        v1 = model_q.size() >= 1;
        v2 = model_q.size() >= 2;
        st = (DEPTH - model_q.size()) < 2;
        if (v1) e1 = model_q[0];
        if (v2) e2 = model_q[1];
        return {v1, v2, st, e1, e2};
    endfunction

    task automatic drive(input logic v1, input ib_entry_t e1, input logic v2, input ib_entry_t e2,
                         input logic r1, input logic r2, input logic fl);
        bus.in_valid1 = v1;
        {bus.in_pc1, bus.in_inst1, bus.in_pred_taken1, bus.in_excp1, bus.in_excp_cause1} = e1;
        bus.in_valid2 = v2;
        {bus.in_pc2, bus.in_inst2, bus.in_pred_taken2, bus.in_excp2, bus.in_excp_cause2} = e2;
        bus.out_ready1 = r1;
        bus.out_ready2 = r2;
        bus.flush      = fl;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock; the model applies the queue rules to the inputs seen at the edge
    task automatic step();
        int        sz;
        int        npop;
        ib_entry_t w[$];
        @(posedge clk);
        if (rst || bus.flush) begin
            model_q.delete();
        end else begin
            sz   = model_q.size();
            npop = 0;
            if (bus.out_ready1 && sz >= 1) npop = (bus.out_ready2 && sz >= 2) ? 2 : 1;
            if (bus.in_valid1)
                w.push_back({bus.in_pc1, bus.in_inst1, bus.in_pred_taken1, bus.in_excp1, bus.in_excp_cause1});
            if (bus.in_valid2)
                w.push_back({bus.in_pc2, bus.in_inst2, bus.in_pred_taken2, bus.in_excp2, bus.in_excp_cause2});
            repeat (npop) void'(model_q.pop_front());
            for (int i = 0; i < w.size() && i < DEPTH - sz; i++) model_q.push_back(w[i]);
        end
        #1;
    endtask

    task automatic do_flush();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        total++;
        if (obs_vec() !== 149'd0) begin
            bad++;
            $display("FAIL reset_state: got %h expected 0", obs_vec());
        end
        rst = 1'b0;
        step();
        total++;
        if (obs_vec() !== exp_vec() || bus.stall_to_pc !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        do_flush();
        drive(1'b1, mk(32'h1c000000, 32'h02800c0c), 1'b1, mk(32'h1c000004, 32'h02801000), 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (bus.out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL basic_no_bypass: out_valid1 got %b expected 0", bus.out_valid1);
        end
        step();
        idle();
        total++;
        if (bus.out_valid1 !== 1'b1 || bus.out_valid2 !== 1'b1 ||
            bus.out_pc1 !== 32'h1c000000 || bus.out_pc2 !== 32'h1c000004 ||
            bus.out_inst1 !== 32'h02800c0c || bus.out_inst2 !== 32'h02801000) begin
            bad++;
            $display("FAIL basic_write2: got v=%b%b pc1=%h pc2=%h expected v=11 pc1=1c000000 pc2=1c000004",
                     bus.out_valid1, bus.out_valid2, bus.out_pc1, bus.out_pc2);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] got_pcs[$];
        logic [31:0] base = 32'h1c000100;
        do_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(base + 32'(8*i), 32'(i)), 1'b1, mk(base + 32'(8*i+4), 32'(i+100)), 1'b0, 1'b0, 1'b0);
            step();
        end
        idle();
        total++;
        if (bus.stall_to_pc !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL fill_six_no_stall: stall got %b expected 0", bus.stall_to_pc);
        end
        drive(1'b1, mk(base + 32'd24, 32'd7), 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        total++;
        if (bus.stall_to_pc !== 1'b1) begin
            bad++;
            $display("FAIL fill_seven_stall: stall got %b expected 1", bus.stall_to_pc);
        end
        drive(1'b1, mk(base + 32'd28, 32'd8), 1'b1, mk(base + 32'd32, 32'd9), 1'b0, 1'b0, 1'b0);
        step();
        idle();
        total++;
        if (bus.stall_to_pc !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL fill_overflow: got %h expected %h", obs_vec(), exp_vec());
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 10 && bus.out_valid1; c++) begin
            got_pcs.push_back(bus.out_pc1);
            if (bus.out_valid2) got_pcs.push_back(bus.out_pc2);
            step();
        end
        idle();
        total++;
        if (got_pcs.size() != 8) begin
            bad++;
            $display("FAIL fill_drain_count: got %0d expected 8", got_pcs.size());
        end
        for (int i = 0; i < got_pcs.size() && i < 8; i++) begin
            total++;
            if (got_pcs[i] !== base + 32'(4*i)) begin
                bad++;
                $display("FAIL fill_drain_order[%0d]: got %h expected %h", i, got_pcs[i], base + 32'(4*i));
            end
        end
    endtask

    task automatic test_slot2_only();
        do_flush();
        drive(1'b0, mk(32'hdeadbeef, 32'h0), 1'b1, mk(32'h1c000014, 32'h4c000020), 1'b0, 1'b0, 1'b0);
        step();
        idle();
        total++;
        if (bus.out_valid1 !== 1'b1 || bus.out_valid2 !== 1'b0 || bus.out_pc1 !== 32'h1c000014 ||
            bus.out_pc2 !== 32'h0) begin
            bad++;
            $display("FAIL slot2_only: got v=%b%b pc1=%h pc2=%h expected v=10 pc1=1c000014 pc2=0",
                     bus.out_valid1, bus.out_valid2, bus.out_pc1, bus.out_pc2);
        end
    endtask

    task automatic test_pop_order_wrap();
        do_flush();
        drive(1'b1, mk(32'h1c000200, 32'h1), 1'b1, mk(32'h1c000204, 32'h2), 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step();
        total++;
        if (bus.out_valid2 !== 1'b1 || bus.out_pc1 !== 32'h1c000200 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL pop_ready2_only: pc1 got %h expected 1c000200 valid2 got %b expected 1",
                     bus.out_pc1, bus.out_valid2);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, mk(32'h1c001000 + 32'(8*i), $urandom()), 1'b1,
                  mk(32'h1c001004 + 32'(8*i), $urandom()), 1'b1, 1'b1, 1'b0);
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL pop_wrap[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        idle();
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rand_entry(), (i < 2), rand_entry(), 1'b0, 1'b0, 1'b0);
            step();
        end
        total++;
        if (model_q.size() != 5 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL flush_prefill: got %h expected %h", obs_vec(), exp_vec());
        end
        drive(1'b1, rand_entry(), 1'b1, rand_entry(), 1'b1, 1'b1, 1'b1);
        step();
        idle();
        total++;
        if (bus.out_valid1 !== 1'b0 || bus.out_valid2 !== 1'b0 || bus.stall_to_pc !== 1'b0 ||
            obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL flush_clear: got %h expected 0", obs_vec());
        end
        step();
        total++;
        if (obs_vec() !== 149'd0) begin
            bad++;
            $display("FAIL flush_after: got %h expected 0", obs_vec());
        end
    endtask

    task automatic test_excp_passthrough();
        ib_entry_t e1, e2;
        do_flush();
        e1 = '{pc: 32'h1c000031, inst: 32'h0, pred_taken: 1'b1, excp: 1'b1, cause: 7'h08};
        e2 = '{pc: 32'h1c000040, inst: 32'h58000400, pred_taken: 1'b1, excp: 1'b0, cause: 7'h00};
        drive(1'b1, e1, 1'b1, e2, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        total++;
        if (bus.out_excp1 !== 1'b1 || bus.out_excp_cause1 !== 7'h08 || bus.out_pred_taken1 !== 1'b1 ||
            bus.out_pc1 !== 32'h1c000031 || bus.out_excp2 !== 1'b0 || bus.out_pred_taken2 !== 1'b1) begin
            bad++;
            $display("FAIL excp_fields: got excp1=%b cause1=%h pred1=%b excp2=%b pred2=%b expected 1 08 1 0 1",
                     bus.out_excp1, bus.out_excp_cause1, bus.out_pred_taken1, bus.out_excp2, bus.out_pred_taken2);
        end
    endtask

    task automatic test_async_reset();
        do_flush();
        drive(1'b1, rand_entry(), 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, rand_entry(), 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL areset_prefill: got %h expected %h", obs_vec(), exp_vec());
        end
        #2;
        rst = 1'b1;
        model_q.delete();
        #1;
        total++;
        if (obs_vec() !== 149'd0) begin
            bad++;
            $display("FAIL areset_immediate: got %h expected 0", obs_vec());
        end
        step();
        rst = 1'b0;
        drive(1'b0, '0, 1'b1, mk(32'h1c000300, 32'h3), 1'b0, 1'b0, 1'b0);
        step();
        idle();
        total++;
        if (bus.out_pc1 !== 32'h1c000300 || bus.out_valid2 !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL areset_resume: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_flush();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, rand_entry(), $urandom_range(0, 9) < 6, rand_entry(),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 5, $urandom_range(0, 31) == 0);
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_slot2_only();
        test_pop_order_wrap();
        test_flush();
        test_excp_passthrough();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
